four_digit_led_driver: RTL

//  Time-multiplexed driver for the board's 4-digit common-anode 7-segment display, clocked by the divided DCM clock.

---
 rtl/four_digit_led_driver_pkg.sv | 33 +++
 rtl/four_digit_led_driver_hex_to_7seg.sv | 35 +++
 rtl/four_digit_led_driver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/four_digit_led_driver_pkg.sv
// Shared constants for the 4-digit 7-segment display driver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Segment patterns are active-low in {a,b,c,d,e,f,g} = seg[6:0] order.
package four_digit_led_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'h01;
    localparam logic [6:0] SEG_1   = 7'h4F;
    localparam logic [6:0] SEG_2   = 7'h12;
    localparam logic [6:0] SEG_3   = 7'h06;
    localparam logic [6:0] SEG_4   = 7'h4C;
    localparam logic [6:0] SEG_5   = 7'h24;
    localparam logic [6:0] SEG_6   = 7'h20;
    localparam logic [6:0] SEG_7   = 7'h0F;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h04;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h60;
    localparam logic [6:0] SEG_C   = 7'h31;
    localparam logic [6:0] SEG_D   = 7'h42;
    localparam logic [6:0] SEG_E   = 7'h30;
    localparam logic [6:0] SEG_F   = 7'h38;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] ANODES_OFF = 4'hF;

    // Per-slot scan state: anodes dark during BLANK, one anode lit during SHOW.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/four_digit_led_driver_hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none.
// Ports: hex (4-bit nibble in), seg (7-bit active-low {a..g} out).
module hex_to_7seg
    import four_digit_led_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/four_digit_led_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with a shadowed load port.
// Latency: accepted value appears at digit 3, slot cycle 0, of the frame after the next frame boundary.
// Backpressure: load_ready low while the shadow holds an uncommitted value; frees at the frame boundary.
// Ports: clk, reset_n (sync, active-low); load_data/load_dp/load_valid/load_ready load port;
//        digit_en live anode mask; an/seg/dp active-low display pins; frame_done boundary pulse.
module four_digit_led_driver
    import four_digit_led_driver_pkg::*;
#(
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt, nxt_cnt;
    logic [1:0]       digit_idx, nxt_idx;
    slot_state_t      state, nxt_state;
    logic [15:0]      disp_reg, nxt_disp;
    logic [3:0]       disp_dp, nxt_disp_dp;
    logic [15:0]      shadow_data;
    logic [3:0]       shadow_dp;
    logic             shadow_full;
    logic             slot_wrap, boundary, commit, load_fire;
    logic [3:0]       nxt_nibble;
    logic [6:0]       nxt_seg;
    logic [3:0]       nxt_an;
    logic             nxt_dp_pin;
    logic             nxt_frame_done;

    // Shadow empty is a register, so load_ready stays a registered output.
    assign load_ready = ~shadow_full;

    // Output registers are loaded from next-state values so that the pins line up
    // with slot_cnt/digit_idx of the same cycle (pattern present from slot cycle 0).
    always_comb begin
        slot_wrap   = (slot_cnt == LAST_CNT);
        nxt_cnt     = slot_wrap ? '0 : slot_cnt + 1'b1;
        nxt_idx     = slot_wrap ? digit_idx - 2'd1 : digit_idx;
        boundary    = slot_wrap && (digit_idx == 2'd0);
        commit      = boundary && shadow_full;
        load_fire   = load_valid && load_ready;
        nxt_disp    = commit ? shadow_data : disp_reg;
        nxt_disp_dp = commit ? shadow_dp   : disp_dp;
        nxt_nibble  = nxt_disp[{nxt_idx, 2'b00} +: 4];
        nxt_dp_pin  = ~nxt_disp_dp[nxt_idx];
        nxt_frame_done = (nxt_idx == 2'd0) && (nxt_cnt == LAST_CNT);
    end

    hex_to_7seg u_hex_to_7seg (
        .hex (nxt_nibble),
        .seg (nxt_seg)
    );

    // Slot FSM, next-state and anode decode.
    always_comb begin
        nxt_state = state;
        nxt_an    = ANODES_OFF;
        case (state)
            ST_BLANK: if (nxt_cnt == BLANK_END) nxt_state = ST_SHOW;
            ST_SHOW:  if (slot_wrap)            nxt_state = ST_BLANK;
            default:  nxt_state = ST_BLANK;
        endcase
        // digit_en is live: a cleared bit darkens its anode on the next cycle.
        if (nxt_state == ST_SHOW && digit_en[nxt_idx]) begin
            nxt_an[nxt_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_BLANK;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt    <= '0;
            digit_idx   <= 2'd3;
            disp_reg    <= '0;
            disp_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_full <= 1'b0;
            an          <= ANODES_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            slot_cnt   <= nxt_cnt;
            digit_idx  <= nxt_idx;
            disp_reg   <= nxt_disp;
            disp_dp    <= nxt_disp_dp;
            an         <= nxt_an;
            seg        <= nxt_seg;
            dp         <= nxt_dp_pin;
            frame_done <= nxt_frame_done;
            // A transfer on the boundary cycle only happens when the shadow is
            // empty, so it never collides with a commit; it waits a full frame.
            if (load_fire) begin
                shadow_data <= load_data;
                shadow_dp   <= load_dp;
                shadow_full <= 1'b1;
            end else if (commit) begin
                shadow_full <= 1'b0;
            end
        end
    end

endmodule
